alu_ctrl: RTL and testbench

Multi-cycle sequencer sitting directly upstream of the 8-bit ALU. Accepts one instruction at a time over a valid/ready handshake and drives the ALU select lines and operands from an internal accumulator and the instruction immediate. Captures the ALU result and carry into the accumulator and carry flag, then returns the result over a second valid/ready handshake.

---
 rtl/alu_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: single-issue sequencer in front of the 8-bit ALU.
// Holds the accumulator and carry, drives ALU selects, returns results.
module alu_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic [3:0] instr_op_i,
  input  logic [7:0] instr_imm_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [7:0] res_data_o,
  output logic       res_cf_o,
  output logic       res_zf_o,
  output logic       res_err_o,
  output logic [7:0] acc_o,
  output logic       cf_sel_o,
  output logic       alu_sel_0_o,
  output logic [1:0] alu_sel_1_o,
  output logic       inv_sel_o,
  output logic       shftr_sel_o,
  output logic       shftl_sel_o,
  output logic [7:0] oprnd_0_o,
  output logic [7:0] oprnd_1_o,
  input  logic [7:0] alu_result_i,
  input  logic       cf_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_LDA = 4'd8;
  localparam logic [3:0] OP_CLC = 4'd9;

  state_t     state;
  logic [7:0] acc;
  logic       cf;
  logic [3:0] op_q;
  logic [7:0] imm_q;
  logic       err_q;
  logic       cf_upd;

  assign instr_ready_o = (state == IDLE);
  assign res_valid_o   = (state == RESP);
  assign res_data_o    = acc;
  assign res_cf_o      = cf;
  assign res_zf_o      = (acc == 8'h00);
  assign res_err_o     = err_q;
  assign acc_o         = acc;
  assign oprnd_0_o     = acc;
  assign oprnd_1_o     = imm_q;

  // Arithmetic and shifts produce a carry; logic ops leave it alone.
  assign cf_upd = (op_q == OP_ADD) || (op_q == OP_ADC) ||
                  (op_q == OP_SHR) || (op_q == OP_SHL);

  always_comb begin
    cf_sel_o    = 1'b0;
    alu_sel_0_o = 1'b0;
    alu_sel_1_o = 2'b00;
    inv_sel_o   = 1'b0;
    shftr_sel_o = 1'b0;
    shftl_sel_o = 1'b0;
    if (state == EXEC) begin
      case (op_q)
        OP_ADC: cf_sel_o = cf;
        OP_AND: begin
          alu_sel_0_o = 1'b1;
          alu_sel_1_o = 2'b01;
        end
        OP_OR: begin
          alu_sel_0_o = 1'b1;
          alu_sel_1_o = 2'b10;
        end
        OP_XOR: begin
          alu_sel_0_o = 1'b1;
          alu_sel_1_o = 2'b11;
        end
        OP_NOT: inv_sel_o   = 1'b1;
        OP_SHR: shftr_sel_o = 1'b1;
        OP_SHL: shftl_sel_o = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= 8'h00;
      cf    <= 1'b0;
      op_q  <= 4'h0;
      imm_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid_i) begin
            op_q  <= instr_op_i;
            imm_q <= instr_imm_i;
            err_q <= 1'b0;
            if (!instr_op_i[3]) begin
              state <= EXEC;
            end else begin
              // Non-ALU ops complete at the accept edge.
              state <= RESP;
              case (instr_op_i)
                OP_LDA:  acc   <= instr_imm_i;
                OP_CLC:  cf    <= 1'b0;
                default: err_q <= 1'b1;
              endcase
            end
          end
        end
        EXEC: begin
          acc   <= alu_result_i;
          if (cf_upd)
            cf  <= cf_i;
          state <= RESP;
        end
        RESP: begin
          if (res_ready_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: table vectors, directed corner sequences and random
// instructions against a behavioural accumulator model.
module tb_alu_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic [3:0] instr_op_i;
  logic [7:0] instr_imm_i;
  logic       res_valid_o;
  logic       res_ready_i;
  logic [7:0] res_data_o;
  logic       res_cf_o;
  logic       res_zf_o;
  logic       res_err_o;
  logic [7:0] acc_o;
  logic       cf_sel_o;
  logic       alu_sel_0_o;
  logic [1:0] alu_sel_1_o;
  logic       inv_sel_o;
  logic       shftr_sel_o;
  logic       shftl_sel_o;
  logic [7:0] oprnd_0_o;
  logic [7:0] oprnd_1_o;
  logic [7:0] alu_result_i;
  logic       cf_i;

  alu_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_op_i    (instr_op_i),
    .instr_imm_i   (instr_imm_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_data_o    (res_data_o),
    .res_cf_o      (res_cf_o),
    .res_zf_o      (res_zf_o),
    .res_err_o     (res_err_o),
    .acc_o         (acc_o),
    .cf_sel_o      (cf_sel_o),
    .alu_sel_0_o   (alu_sel_0_o),
    .alu_sel_1_o   (alu_sel_1_o),
    .inv_sel_o     (inv_sel_o),
    .shftr_sel_o   (shftr_sel_o),
    .shftl_sel_o   (shftl_sel_o),
    .oprnd_0_o     (oprnd_0_o),
    .oprnd_1_o     (oprnd_1_o),
    .alu_result_i  (alu_result_i),
    .cf_i          (cf_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU answering whatever the selects ask for.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum      = {1'b0, oprnd_0_o} + {1'b0, oprnd_1_o} + {8'h00, cf_sel_o};
    alu_result_i = alu_sum[7:0];
    cf_i         = alu_sum[8];
    if (alu_sel_0_o) begin
      cf_i = 1'b0;
      case (alu_sel_1_o)
        2'b01:   alu_result_i = oprnd_0_o & oprnd_1_o;
        2'b10:   alu_result_i = oprnd_0_o | oprnd_1_o;
        2'b11:   alu_result_i = oprnd_0_o ^ oprnd_1_o;
        default: alu_result_i = 8'h00;
      endcase
    end else if (inv_sel_o) begin
      alu_result_i = ~oprnd_0_o;
      cf_i         = 1'b0;
    end else if (shftr_sel_o) begin
      alu_result_i = oprnd_0_o >> 1;
      cf_i         = oprnd_0_o[0];
    end else if (shftl_sel_o) begin
      alu_result_i = oprnd_0_o << 1;
      cf_i         = oprnd_0_o[7];
    end
  end

  logic [6:0] sel;
  assign sel = {cf_sel_o, alu_sel_0_o, alu_sel_1_o,
                inv_sel_o, shftr_sel_o, shftl_sel_o};

  int vectors = 0;
  int fails   = 0;

  logic [7:0] m_acc;
  logic       m_cf;
  logic       m_err;

  typedef struct {
    logic [3:0] op;
    logic [7:0] imm;
    logic [7:0] data;
    logic       cf;
    logic       err;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_sel(input logic [3:0] op, input logic c);
    case (op)
      4'd1:    return {c, 6'b0_00_000};
      4'd2:    return 7'b0_1_01_000;
      4'd3:    return 7'b0_1_10_000;
      4'd4:    return 7'b0_1_11_000;
      4'd5:    return 7'b0_0_00_100;
      4'd6:    return 7'b0_0_00_010;
      4'd7:    return 7'b0_0_00_001;
      default: return 7'b0;
    endcase
  endfunction

  function automatic void model_step(input logic [3:0] op, input logic [7:0] imm);
    int s;
    m_err = 1'b0;
    case (op)
      4'd0: begin
        s = int'(m_acc) + int'(imm);
        m_acc = 8'(s % 256);
        m_cf = (s > 255);
      end
      4'd1: begin
        s = int'(m_acc) + int'(imm) + (m_cf ? 1 : 0);
        m_acc = 8'(s % 256);
        m_cf = (s > 255);
      end
      4'd2: m_acc = m_acc & imm;
      4'd3: m_acc = m_acc | imm;
      4'd4: m_acc = m_acc ^ imm;
      4'd5: m_acc = ~m_acc;
      4'd6: begin
        m_cf  = m_acc[0];
        m_acc = 8'(int'(m_acc) / 2);
      end
      4'd7: begin
        m_cf  = m_acc[7];
        m_acc = 8'((int'(m_acc) * 2) % 256);
      end
      4'd8: m_acc = imm;
      4'd9: m_cf = 1'b0;
      default: m_err = 1'b1;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [7:0] imm,
                       input logic use_tbl, input logic [7:0] t_data,
                       input logic t_cf, input logic t_err);
    int lat;
    logic alu;
    logic [7:0] ed;
    logic ec, ee;
    alu = (op < 4'd8);
    chk("idle_ready", 32'(instr_ready_o), 32'd1);
    instr_op_i    = op;
    instr_imm_i   = imm;
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    if (alu) begin
      chk("exec_sel", 32'(sel), 32'(exp_sel(op, m_cf)));
      chk("oprnd_0", 32'(oprnd_0_o), 32'(m_acc));
      chk("oprnd_1", 32'(oprnd_1_o), 32'(imm));
      chk("exec_ready", 32'(instr_ready_o), 32'd0);
    end
    model_step(op, imm);
    ed = use_tbl ? t_data : m_acc;
    ec = use_tbl ? t_cf : m_cf;
    ee = use_tbl ? t_err : m_err;
    lat = 0;
    while (!res_valid_o && lat < 4) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("latency", 32'(lat), alu ? 32'd1 : 32'd0);
    chk("res_data", 32'(res_data_o), 32'(ed));
    chk("res_cf", 32'(res_cf_o), 32'(ec));
    chk("res_zf", 32'(res_zf_o), 32'(ed == 8'h00));
    chk("res_err", 32'(res_err_o), 32'(ee));
    chk("resp_sel", 32'(sel), 32'd0);
    res_ready_i = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    chk("post_valid", 32'(res_valid_o), 32'd0);
    chk("post_ready", 32'(instr_ready_o), 32'd1);
    chk("post_sel", 32'(sel), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{4'd8,  8'h7F, 8'h7F, 1'b0, 1'b0};
    tbl[1]  = '{4'd8,  8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[2]  = '{4'd0,  8'h01, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{4'd8,  8'h20, 8'h20, 1'b1, 1'b0};
    tbl[4]  = '{4'd1,  8'h10, 8'h31, 1'b0, 1'b0};
    tbl[5]  = '{4'd9,  8'h00, 8'h31, 1'b0, 1'b0};
    tbl[6]  = '{4'd1,  8'h10, 8'h41, 1'b0, 1'b0};
    tbl[7]  = '{4'd8,  8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[8]  = '{4'd0,  8'h01, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{4'd8,  8'hF0, 8'hF0, 1'b1, 1'b0};
    tbl[10] = '{4'd2,  8'h3C, 8'h30, 1'b1, 1'b0};
    tbl[11] = '{4'd3,  8'h0F, 8'h3F, 1'b1, 1'b0};
    tbl[12] = '{4'd4,  8'hFF, 8'hC0, 1'b1, 1'b0};
    tbl[13] = '{4'd5,  8'h00, 8'h3F, 1'b1, 1'b0};
    tbl[14] = '{4'd6,  8'h00, 8'h1F, 1'b1, 1'b0};
    tbl[15] = '{4'd7,  8'h00, 8'h3E, 1'b0, 1'b0};
    tbl[16] = '{4'd6,  8'h00, 8'h1F, 1'b0, 1'b0};
    tbl[17] = '{4'd8,  8'h81, 8'h81, 1'b0, 1'b0};
    tbl[18] = '{4'd7,  8'h00, 8'h02, 1'b1, 1'b0};
    tbl[19] = '{4'd8,  8'h55, 8'h55, 1'b1, 1'b0};
    tbl[20] = '{4'd12, 8'h12, 8'h55, 1'b1, 1'b1};
    tbl[21] = '{4'd15, 8'h34, 8'h55, 1'b1, 1'b1};
    tbl[22] = '{4'd0,  8'h00, 8'h55, 1'b0, 1'b0};
    tbl[23] = '{4'd8,  8'h00, 8'h00, 1'b0, 1'b0};
    tbl[24] = '{4'd10, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[25] = '{4'd9,  8'h00, 8'h00, 1'b0, 1'b0};

    rst_i         = 1'b1;
    instr_valid_i = 1'b0;
    instr_op_i    = 4'h0;
    instr_imm_i   = 8'h00;
    res_ready_i   = 1'b0;
    m_acc = 8'h00;
    m_cf  = 1'b0;
    m_err = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_ready", 32'(instr_ready_o), 32'd1);
    chk("rst_valid", 32'(res_valid_o), 32'd0);
    chk("rst_acc", 32'(acc_o), 32'd0);
    chk("rst_cf", 32'(res_cf_o), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_imm", 32'(oprnd_1_o), 32'd0);

    for (int i = 0; i < 26; i++)
      issue(tbl[i].op, tbl[i].imm, 1'b1, tbl[i].data, tbl[i].cf, tbl[i].err);

    // Backpressure: response held while new instructions are offered.
    instr_op_i    = 4'd8;
    instr_imm_i   = 8'h12;
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    model_step(4'd8, 8'h12);
    instr_imm_i = 8'h99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(res_valid_o), 32'd1);
      chk("bp_data", 32'(res_data_o), 32'h12);
      chk("bp_ready", 32'(instr_ready_o), 32'd0);
      @(posedge clk_i); #1;
    end
    instr_valid_i = 1'b0;
    res_ready_i   = 1'b1;
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    chk("bp_done_ready", 32'(instr_ready_o), 32'd1);
    chk("bp_done_acc", 32'(acc_o), 32'h12);

    // Consumer ready early: handshake on the first valid edge.
    res_ready_i   = 1'b1;
    instr_op_i    = 4'd0;
    instr_imm_i   = 8'h03;
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    model_step(4'd0, 8'h03);
    @(posedge clk_i); #1;
    chk("early_valid", 32'(res_valid_o), 32'd1);
    chk("early_data", 32'(res_data_o), 32'(m_acc));
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    chk("early_done", 32'(res_valid_o), 32'd0);
    chk("early_ready", 32'(instr_ready_o), 32'd1);

    // Reset in the middle of EXEC aborts the instruction.
    instr_op_i    = 4'd3;
    instr_imm_i   = 8'hA0;
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    chk("abort_sel", 32'(sel), 32'(exp_sel(4'd3, m_cf)));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_acc = 8'h00;
    m_cf  = 1'b0;
    m_err = 1'b0;
    chk("abort_acc", 32'(acc_o), 32'd0);
    chk("abort_ready", 32'(instr_ready_o), 32'd1);
    chk("abort_sel0", 32'(sel), 32'd0);
    repeat (2) begin
      chk("abort_novalid", 32'(res_valid_o), 32'd0);
      @(posedge clk_i); #1;
    end
    chk("abort_cf", 32'(res_cf_o), 32'd0);

    for (int i = 0; i < 60; i++)
      issue(4'($urandom_range(0, 15)), 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
